// File: rtl/lif_spike_dec_pkg.sv
// lif_spike_dec_pkg: shared state type, default widths and saturating increment for the spike decoder.
package lif_spike_dec_pkg;

   typedef enum logic {IDLE, COUNT} dec_state_t;

   localparam int DEF_WIN_W = 16;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_ISI_W = 16;

   // Increment v, holding at the all-ones value of a w-bit field (w <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      return (v == (32'hFFFF_FFFF >> (32 - w))) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/lif_isi_timer.sv
// lif_isi_timer: tracks cycles between spike edges and holds the last completed interval.
module lif_isi_timer
   import lif_spike_dec_pkg::*;
#(
   parameter int ISI_W = DEF_ISI_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             edge_i,
   output logic [ISI_W-1:0] isi_last_o
);

   logic             seen_q, seen_d;
   logic [ISI_W-1:0] cnt_q, cnt_d, last_q, last_d, cnt_inc;

   // The interval includes the edge cycle itself, hence cnt+1 on the closing edge.
   always_comb begin
      cnt_inc = ISI_W'(sat_inc(32'(cnt_q), ISI_W));
      seen_d  = !clr_i && (seen_q || edge_i);
      cnt_d   = (clr_i || edge_i) ? '0 : (seen_q ? cnt_inc : cnt_q);
      last_d  = clr_i ? '0 : ((edge_i && seen_q) ? cnt_inc : last_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seen_q <= 1'b0;
         cnt_q  <= '0;
         last_q <= '0;
      end else begin
         seen_q <= seen_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   assign isi_last_o = last_q;

endmodule

// File: rtl/lif_spike_decoder.sv
// lif_spike_decoder: decodes a spike train into a per-window firing rate and last inter-spike interval.
// Define LIF_SPIKE_DEC_ISI_EN to build the ISI tracker; otherwise isi is tied to 0.
module lif_spike_decoder
   import lif_spike_dec_pkg::*;
#(
   parameter int WIN_W = DEF_WIN_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int ISI_W = DEF_ISI_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             spike_in,
   input  logic [WIN_W-1:0] win_len,
   output logic [CNT_W-1:0] rate_count,
   output logic [ISI_W-1:0] isi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun,
   output logic             busy
);

   localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

   dec_state_t       state_q, state_d;
   logic [WIN_W-1:0] wc_q, wc_d, len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, rate_q, rate_d, cnt_inc;
   logic [ISI_W-1:0] isi_q, isi_d, isi_last;
   logic             spike_q, spike_d, valid_q, valid_d, ovr_q, ovr_d;
   logic             run, spk_edge, last, load;

   // Dropping ena clears the window in the same edge it leaves COUNT.
   always_comb begin
      run      = state_q == COUNT && ena;
      spk_edge = run && spike_in && !spike_q;
      cnt_inc  = spk_edge ? CNT_W'(sat_inc(32'(cnt_q), CNT_W)) : cnt_q;
      last     = run && wc_q == len_q - WIN_ONE;
      load     = last && (!valid_q || out_ready);
      state_d  = ena ? COUNT : IDLE;
      len_d    = ((state_q == IDLE && ena) || last) ? ((win_len == '0) ? WIN_ONE : win_len) : len_q;
      wc_d     = (!run || last) ? '0 : wc_q + WIN_ONE;
      cnt_d    = (!run || last) ? '0 : cnt_inc;
      spike_d  = run ? spike_in : 1'b0;
      rate_d   = load ? cnt_inc : rate_q;
      isi_d    = load ? isi_last : isi_q;
      valid_d  = load || (valid_q && !out_ready);
      ovr_d    = ovr_q || (last && !load);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wc_q    <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         rate_q  <= '0;
         isi_q   <= '0;
         spike_q <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wc_q    <= wc_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         rate_q  <= rate_d;
         isi_q   <= isi_d;
         spike_q <= spike_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef LIF_SPIKE_DEC_ISI_EN
   lif_isi_timer #(.ISI_W(ISI_W)) u_isi (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (!run),
      .edge_i     (spk_edge),
      .isi_last_o (isi_last)
   );
`else
   assign isi_last = '0;
`endif

   assign rate_count = rate_q;
   assign isi        = isi_q;
   assign out_valid  = valid_q;
   assign overrun    = ovr_q;
   assign busy       = state_q == COUNT;

endmodule

// File: tb/tb_lif_spike_decoder.sv
// tb_lif_spike_decoder: scoreboard bench for lif_spike_decoder (default widths).
module tb_lif_spike_decoder;

`ifdef LIF_SPIKE_DEC_ISI_EN
   localparam bit ISI_ON = 1'b1;
`else
   localparam bit ISI_ON = 1'b0;
`endif

   typedef struct {int rate; int isi;} res_t;

   logic        clk = 1'b0;
   logic        rst, ena, spike_in, out_ready;
   logic [15:0] win_len;
   logic [7:0]  rate_count;
   logic [15:0] isi;
   logic        out_valid, overrun, busy;

   int   n_chk = 0, n_err = 0, n_acc = 0, l_rate = 0, l_isi = 0, base;
   res_t sb[$];
   int   acc_log[$];

   bit m_st, m_sq, m_seen, m_valid, m_ovr;
   int m_wc, m_len, m_cnt, m_ic, m_il;

   lif_spike_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .spike_in   (spike_in),
      .win_len    (win_len),
      .rate_count (rate_count),
      .isi        (isi),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: behavioural decoder, pushes each result it expects to be loaded.
   always @(posedge clk or posedge rst) begin
      bit run, e, last, ld;
      int c;
      if (rst) begin
         m_st = 0; m_sq = 0; m_seen = 0; m_valid = 0; m_ovr = 0;
         m_wc = 0; m_len = 1; m_cnt = 0; m_ic = 0; m_il = 0;
         sb.delete();
      end else begin
         run  = m_st && ena;
         e    = run && spike_in && !m_sq;
         c    = (e && m_cnt < 255) ? m_cnt + 1 : m_cnt;
         last = run && (m_wc == m_len - 1);
         ld   = last && (!m_valid || out_ready);
         if (ld) sb.push_back('{c, ISI_ON ? m_il : 0});
         if (last && !ld) m_ovr = 1;
         m_valid = ld || (m_valid && !out_ready);
         if (!run) begin
            m_sq = 0; m_wc = 0; m_cnt = 0; m_seen = 0; m_ic = 0; m_il = 0;
         end else begin
            m_sq = spike_in;
            if (e) begin
               if (m_seen) m_il = (m_ic + 1 > 65535) ? 65535 : m_ic + 1;
               m_ic = 0;
               m_seen = 1;
            end else if (m_seen && m_ic < 65535) m_ic++;
            m_wc  = last ? 0 : m_wc + 1;
            m_cnt = last ? 0 : c;
         end
         if ((!m_st && ena) || last) m_len = (win_len == 0) ? 1 : int'(win_len);
         m_st = ena;
      end
   end

   // Monitor: compares flags every cycle and each accepted result against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         chk("out_valid", out_valid, m_valid);
         chk("overrun", overrun, m_ovr);
         chk("busy", busy, m_st);
         if (out_valid && out_ready) begin
            n_acc++;
            l_rate = rate_count;
            l_isi  = isi;
            acc_log.push_back(rate_count);
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               chk("sb_rate", rate_count, sb[0].rate);
               chk("sb_isi", isi, sb[0].isi);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1; ena = 1; spike_in = 0; out_ready = 1; win_len = 5;
      for (int i = 0; i < 4; i++) begin
         tick();
         spike_in = ~spike_in;
      end
      @(negedge clk);
      chk("rst_rate", rate_count, 0);
      chk("rst_isi", isi, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_busy", busy, 0);
      tick();
      rst = 0; spike_in = 0;
      @(negedge clk);
      chk("busy_pre", busy, 0);
      @(negedge clk);
      chk("busy_post", busy, 1);
      tick();
      ena = 0;
      tick(); tick();

      // basic: 10-cycle windows, spikes at window cycles 1,4,7
      base = n_acc; win_len = 10; ena = 1;
      for (int k = 0; k < 20; k++) begin
         tick();
         spike_in = (k % 10 == 1) || (k % 10 == 4) || (k % 10 == 7);
      end
      tick(); ena = 0; spike_in = 0; tick(); tick();
      chk("basic_n", n_acc - base, 2);
      chk("basic_rate", l_rate, 3);
      chk("basic_isi", l_isi, ISI_ON ? 3 : 0);

      // held spike counts once; edge on the last window cycle is counted
      base = n_acc; win_len = 8; ena = 1;
      for (int k = 0; k < 8; k++) begin
         tick();
         spike_in = (k >= 1 && k <= 5) || k == 7;
      end
      tick(); ena = 0; spike_in = 0; tick(); tick();
      chk("held_n", n_acc - base, 1);
      chk("held_rate", l_rate, 2);
      chk("held_isi", l_isi, 0);

      // win_len=0 gives one-cycle windows
      base = n_acc; win_len = 0; ena = 1;
      for (int k = 0; k < 6; k++) begin
         tick();
         spike_in = (k % 2 == 0);
      end
      tick(); ena = 0; spike_in = 0; tick(); tick();
      chk("len0_n", n_acc - base, 6);
      chk("len0_rate", l_rate, 0);
      chk("len0_isi", l_isi, ISI_ON ? 2 : 0);

      // backpressure for two windows, then release
      acc_log.delete(); win_len = 4; out_ready = 0; ena = 1;
      for (int k = 0; k < 12; k++) begin
         tick();
         spike_in = (k == 1) || (k == 4) || (k == 6) || (k == 8) || (k == 10);
         out_ready = (k >= 8);
      end
      tick(); ena = 0; spike_in = 0; tick(); tick();
      chk("bp_ovr", overrun, 1);
      chk("bp_n", acc_log.size(), 2);
      chk("bp_first", acc_log.size() > 0 ? acc_log[0] : -1, 1);
      chk("bp_second", acc_log.size() > 1 ? acc_log[1] : -1, 2);
      chk("bp_isi", l_isi, ISI_ON ? 2 : 0);

      // rate saturation
      base = n_acc; win_len = 1000; ena = 1;
      for (int k = 0; k < 1000; k++) begin
         tick();
         spike_in = (k % 2 == 0);
      end
      tick(); ena = 0; spike_in = 0; tick(); tick();
      chk("sat_n", n_acc - base, 1);
      chk("sat_rate", l_rate, 255);

      // ISI saturation: long silence between two edges
      base = n_acc; win_len = 33000; ena = 1;
      for (int k = 0; k < 66000; k++) begin
         tick();
         spike_in = (k == 0) || (k == 65600);
      end
      tick(); ena = 0; spike_in = 0; tick(); tick();
      chk("isisat_n", n_acc - base, 2);
      chk("isisat_rate", l_rate, 1);
      chk("isisat_isi", l_isi, ISI_ON ? 65535 : 0);

      // disable at wc=5 discards the window and clears the ISI tracker
      base = n_acc; win_len = 10; ena = 1;
      for (int k = 0; k < 6; k++) begin
         tick();
         spike_in = (k == 1) || (k == 3);
         if (k == 5) ena = 0;
      end
      spike_in = 0; tick(); tick(); tick();
      chk("dis_n", n_acc - base, 0);
      base = n_acc; ena = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         spike_in = (k == 3);
      end
      tick(); ena = 0; spike_in = 0; tick(); tick();
      chk("reen_n", n_acc - base, 1);
      chk("reen_rate", l_rate, 1);
      chk("reen_isi", l_isi, 0);
      chk("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
